// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the AXI-Stream packet arbiter.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int C_PKT_COUNT_WIDTH = 32;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping modulo C_NUM_REQ.
module rr_select #(
    parameter int C_NUM_REQ   = 4,
    parameter int C_IDX_WIDTH = 2
) (
    input  logic [C_NUM_REQ-1:0]   req_i,
    input  logic [C_IDX_WIDTH-1:0] ptr_i,
    output logic [C_IDX_WIDTH-1:0] idx_o,
    output logic                   found_o
);

    localparam logic [C_IDX_WIDTH:0] C_NUM_W = (C_IDX_WIDTH + 1)'(C_NUM_REQ);

    logic [C_IDX_WIDTH:0]   sum_s;
    logic [C_IDX_WIDTH-1:0] cand_s;

    // Scan offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        for (int off = C_NUM_REQ - 1; off >= 0; off--) begin
            sum_s   = {1'b0, ptr_i} + (C_IDX_WIDTH + 1)'(off);
            sum_s   = (sum_s >= C_NUM_W) ? (sum_s - C_NUM_W) : sum_s;
            cand_s  = sum_s[C_IDX_WIDTH-1:0];
            idx_o   = req_i[cand_s] ? cand_s : idx_o;
            found_o = found_o | req_i[cand_s];
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Round-robin, whole-packet AXI-Stream merger with pass-through datapath.
// Optional per-source packet counters: define AXIS_PACKET_ARBITER_PKT_COUNT_EN.
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int C_NUM_INPUTS = 4,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_USER_WIDTH = 1,
    parameter int C_IDX_WIDTH  = (C_NUM_INPUTS > 1) ? $clog2(C_NUM_INPUTS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [C_NUM_INPUTS*C_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [C_NUM_INPUTS*C_USER_WIDTH-1:0] s_axis_tuser,
    input  logic [C_NUM_INPUTS-1:0]              s_axis_tlast,
    input  logic [C_NUM_INPUTS-1:0]              s_axis_tvalid,
    output logic [C_NUM_INPUTS-1:0]              s_axis_tready,
    output logic [C_DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [C_USER_WIDTH-1:0]              m_axis_tuser,
    output logic [C_IDX_WIDTH-1:0]               m_axis_tdest,
    output logic                                 m_axis_tlast,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 busy,
    output logic [C_IDX_WIDTH-1:0]               grant_idx,
    output logic [C_NUM_INPUTS*32-1:0]           pkt_count
);

    localparam logic [C_IDX_WIDTH-1:0] C_LAST_IDX = C_IDX_WIDTH'(C_NUM_INPUTS - 1);

    arb_state_t             state_q, state_d;
    logic [C_IDX_WIDTH-1:0] grant_q, grant_d;
    logic [C_IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [C_IDX_WIDTH-1:0] sel_idx_s;
    logic                   sel_found_s;
    logic                   eop_s;

    rr_select #(
        .C_NUM_REQ   (C_NUM_INPUTS),
        .C_IDX_WIDTH (C_IDX_WIDTH)
    ) u_rr_select (
        .req_i   (s_axis_tvalid),
        .ptr_i   (ptr_q),
        .idx_o   (sel_idx_s),
        .found_o (sel_found_s)
    );

    // Arbitration state, grant and priority pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic and the granted-source pass-through.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        eop_s         = 1'b0;
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tuser  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdest  = grant_q;
        case (state_q)
            IDLE: begin
                if (sel_found_s) begin
                    grant_d = sel_idx_s;
                    state_d = XFER;
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                m_axis_tdata           = s_axis_tdata[int'(grant_q)*C_DATA_WIDTH +: C_DATA_WIDTH];
                m_axis_tuser           = s_axis_tuser[int'(grant_q)*C_USER_WIDTH +: C_USER_WIDTH];
                m_axis_tlast           = s_axis_tlast[grant_q];
                m_axis_tvalid          = s_axis_tvalid[grant_q];
                s_axis_tready[grant_q] = m_axis_tready;
                eop_s = s_axis_tvalid[grant_q] & m_axis_tready & s_axis_tlast[grant_q];
                if (eop_s) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == C_LAST_IDX) ? '0 : grant_q + C_IDX_WIDTH'(1);
                end else begin
                    state_d = XFER;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q == XFER);
    assign grant_idx = grant_q;

`ifdef AXIS_PACKET_ARBITER_PKT_COUNT_EN
    for (genvar gi = 0; gi < C_NUM_INPUTS; gi++) begin : g_cnt
        logic [C_PKT_COUNT_WIDTH-1:0] cnt_q;

        // Free-running accepted-packet counter for source gi; wraps naturally.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (eop_s && (grant_q == C_IDX_WIDTH'(gi))) begin
                cnt_q <= cnt_q + 32'd1;
            end else begin
                cnt_q <= cnt_q;
            end
        end

        assign pkt_count[gi*C_PKT_COUNT_WIDTH +: C_PKT_COUNT_WIDTH] = cnt_q;
    end
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Randomized bench for axis_packet_arbiter against a packet-level round-robin reference model.
module tb_axis_packet_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int UW = 1;
    localparam int IW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N*DW-1:0]   s_tdata;
    logic [N*UW-1:0]   s_tuser;
    logic [N-1:0]      s_tlast, s_tvalid, s_tready;
    logic [DW-1:0]     m_tdata;
    logic [UW-1:0]     m_tuser;
    logic [IW-1:0]     m_tdest, grant_idx;
    logic              m_tlast, m_tvalid, m_tready, busy;
    logic [N*32-1:0]   pkt_count;

    always #5 clk = ~clk;

    axis_packet_arbiter #(
        .C_NUM_INPUTS (N),
        .C_DATA_WIDTH (DW),
        .C_USER_WIDTH (UW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tuser  (s_tuser),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tuser  (m_tuser),
        .m_axis_tdest  (m_tdest),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .busy          (busy),
        .grant_idx     (grant_idx),
        .pkt_count     (pkt_count)
    );

    int checks   = 0;
    int failures = 0;

    beat_t       srcq [N][$];
    beat_t       expq [N][$];
    bit  [N-1:0] hold;
    int          grant_log [$];

    // Reference model: packet-level view of the arbiter.
    bit          m_busy;
    int          m_grant;
    int          m_ptr;
    int unsigned m_cnt [N];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic add_pkt(input int s, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = $urandom;
            b.user = UW'(k == 0);
            b.last = (k == len - 1);
            srcq[s].push_back(b);
            expq[s].push_back(b);
        end
    endtask

    task automatic drive(input int vprob, input int rprob);
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0 && (hold[i] || $urandom_range(99) < vprob)) begin
                hold[i]                 = 1'b1;
                s_tvalid[i]             = 1'b1;
                s_tdata[i*DW +: DW]     = srcq[i][0].data;
                s_tuser[i*UW +: UW]     = srcq[i][0].user;
                s_tlast[i]              = srcq[i][0].last;
            end else begin
                s_tvalid[i]             = 1'b0;
                s_tdata[i*DW +: DW]     = $urandom;
                s_tuser[i*UW +: UW]     = UW'($urandom_range(1));
                s_tlast[i]              = 1'($urandom_range(1));
            end
        end
        m_tready = ($urandom_range(99) < rprob);
    endtask

    // Check outputs mid-cycle, then advance the model across the next rising edge.
    task automatic step();
        beat_t e;
        int    g;
        #4;
        check_eq("busy", 64'(busy), 64'(m_busy));
        check_eq("grant_idx", 64'(grant_idx), 64'(m_grant));
        if (m_busy) begin
            check_eq("m_tvalid", 64'(m_tvalid), 64'(s_tvalid[m_grant]));
            check_eq("m_tdest", 64'(m_tdest), 64'(m_grant));
            check_eq("s_tready", 64'(s_tready), 64'(N'(m_tready) << m_grant));
        end else begin
            check_eq("m_tvalid_idle", 64'(m_tvalid), 64'd0);
            check_eq("s_tready_idle", 64'(s_tready), 64'd0);
        end
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_grant = 0;
            m_ptr   = 0;
            hold    = '0;
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0;
                srcq[i].delete();
                expq[i].delete();
            end
        end else if (m_busy) begin
            if (s_tvalid[m_grant] && m_tready) begin
                e = expq[m_grant].pop_front();
                void'(srcq[m_grant].pop_front());
                hold[m_grant] = 1'b0;
                check_eq("beat", {m_tdata, m_tuser, m_tlast}, 64'(e));
                if (e.last) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_grant + 1) % N;
                    m_cnt[m_grant]++;
                end
            end
        end else begin
            g = rr_pick(s_tvalid, m_ptr);
            if (g >= 0) begin
                m_busy  = 1'b1;
                m_grant = g;
                grant_log.push_back(g);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int vprob, input int rprob);
        for (int c = 0; c < n; c++) begin
            drive(vprob, rprob);
            step();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run(2, 0, 100);
        rst_n = 1'b1;
    endtask

    function automatic bit pending();
        bit p = m_busy;
        for (int i = 0; i < N; i++) p |= (srcq[i].size() > 0);
        return p;
    endfunction

    task automatic drain(input string tag);
        int budget = 600;
        while (pending() && budget > 0) begin
            run(1, 100, 100);
            budget--;
        end
        check_eq(tag, 64'(pending()), 64'd0);
    endtask

    initial begin
        int base;
        m_busy   = 1'b0;
        m_grant  = 0;
        m_ptr    = 0;
        hold     = '0;
        rst_n    = 1'b0;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tuser  = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single 3-beat packet from source 1, sink always ready.
        add_pkt(1, 3);
        drain("drain_t1");
        check_eq("t1_grant", 64'(grant_log[grant_log.size()-1]), 64'd1);

        // All four sources continuously valid: grants 0,1,2,3,0.
        do_reset();
        base = grant_log.size();
        for (int i = 0; i < N; i++) begin
            add_pkt(i, 2);
            add_pkt(i, 2);
        end
        drain("drain_t2");
        for (int k = 0; k < 5; k++) begin
            check_eq("t2_order", 64'(grant_log[base + k]), 64'(k % N));
        end

        // Random source stalls and sink backpressure.
        for (int c = 0; c < 1200; c++) begin
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() < 4 && $urandom_range(99) < 15) add_pkt(i, $urandom_range(1, 5));
            end
            run(1, 55, 65);
        end
        drain("drain_rand");

        // Reset during beat 2 of a source-3 packet, then sources 0 and 3 compete.
        add_pkt(3, 4);
        run(2, 100, 100);
        rst_n = 1'b0;
        drive(100, 100);
        step();
        rst_n = 1'b1;
        base = grant_log.size();
        add_pkt(0, 2);
        add_pkt(3, 2);
        drain("drain_t5");
        check_eq("t5_grant", 64'(grant_log[base]), 64'd0);

        // Packet counters.
        do_reset();
        for (int k = 0; k < 5; k++) add_pkt(1, $urandom_range(1, 3));
        add_pkt(3, 2);
        add_pkt(3, 1);
        drain("drain_t6");
`ifdef AXIS_PACKET_ARBITER_PKT_COUNT_EN
        check_eq("cnt0", 64'(pkt_count[0*32 +: 32]), 64'd0);
        check_eq("cnt1", 64'(pkt_count[1*32 +: 32]), 64'd5);
        check_eq("cnt2", 64'(pkt_count[2*32 +: 32]), 64'd0);
        check_eq("cnt3", 64'(pkt_count[3*32 +: 32]), 64'd2);
        force dut.g_cnt[1].cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.g_cnt[1].cnt_q;
        add_pkt(1, 2);
        drain("drain_wrap");
        check_eq("cnt1_wrap", 64'(pkt_count[1*32 +: 32]), 64'd0);
        check_eq("cnt3_keep", 64'(pkt_count[3*32 +: 32]), 64'd2);
`else
        check_eq("cnt_tied", 64'(pkt_count), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
